// File: rtl/cu_pkg.sv
// Shared encodings, the EX control bundle and the MUL/DIV sequencer state for cu_pipe.
package cu_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MD   = 7'b0000001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_J = 3'b110;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_MD  = 2'b11;

  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [4:0] BR_JUMP = 5'b10000;

  typedef struct packed {
    logic       alua;
    logic       alub;
    logic       dmwr;
    logic       ruwr;
    logic [1:0] wbsrc;
    logic [2:0] immsrc;
    logic [2:0] dmctrl;
    logic [3:0] aluop;
    logic [4:0] brop;
    logic [3:0] mdop;
  } ctrl_t;

  typedef enum logic {IDLE, BUSY} md_state_t;
endpackage

// File: rtl/cu_if.sv
// DE-side instruction/hazard inputs and EX-side control outputs of the control unit.
interface cu_if;
  logic [6:0] OpCode;
  logic [6:0] Funct7;
  logic [2:0] Funct3;
  logic       Valid_de;
  logic       Stall_i;
  logic       Flush_i;
  logic       ALUASrc_ex;
  logic       ALUBSrc_ex;
  logic       DMWr_ex;
  logic       RUWr_ex;
  logic [1:0] RuDataWrSrc_ex;
  logic [2:0] ImmSrc_ex;
  logic [2:0] DMCtrl_ex;
  logic [3:0] ALUOp_ex;
  logic [4:0] BrOp_ex;
  logic [3:0] MDOp_ex;
  logic       Valid_ex;
  logic       Illegal_ex;
  logic       MDBusy;
  logic       MDDone;

  modport master (
    output OpCode, Funct7, Funct3, Valid_de, Stall_i, Flush_i,
    input  ALUASrc_ex, ALUBSrc_ex, DMWr_ex, RUWr_ex, RuDataWrSrc_ex, ImmSrc_ex,
           DMCtrl_ex, ALUOp_ex, BrOp_ex, MDOp_ex, Valid_ex, Illegal_ex, MDBusy, MDDone
  );
  modport slave (
    input  OpCode, Funct7, Funct3, Valid_de, Stall_i, Flush_i,
    output ALUASrc_ex, ALUBSrc_ex, DMWr_ex, RUWr_ex, RuDataWrSrc_ex, ImmSrc_ex,
           DMCtrl_ex, ALUOp_ex, BrOp_ex, MDOp_ex, Valid_ex, Illegal_ex, MDBusy, MDDone
  );
endinterface

// File: rtl/cu_decode.sv
// Combinational RV32I(+M) decode: opcode/funct fields to the EX control bundle and an illegal flag.
module cu_decode
  import cu_pkg::*;
#(
  parameter int EN_M = 1
) (
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output ctrl_t      ctrl,
  output logic       illegal
);
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.ruwr = 1'b1;
        if (funct7 == FUNCT7_BASE) begin
          ctrl.aluop = {1'b0, funct3};
        end else if (funct7 == FUNCT7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          ctrl.aluop = {1'b1, funct3};
        end else if (funct7 == FUNCT7_MD && EN_M != 0) begin
          ctrl.wbsrc = WB_MD;
          ctrl.mdop  = {1'b1, funct3};
        end else begin
          illegal = 1'b1;
        end
      end
      OP_I: begin
        ctrl.ruwr  = 1'b1;
        ctrl.alub  = 1'b1;
        ctrl.aluop = (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
      end
      OP_LOAD: begin
        ctrl.ruwr   = 1'b1;
        ctrl.alub   = 1'b1;
        ctrl.immsrc = IMM_I;
        ctrl.wbsrc  = WB_MEM;
        ctrl.dmctrl = funct3;
      end
      OP_JALR: begin
        ctrl.ruwr  = 1'b1;
        ctrl.alub  = 1'b1;
        ctrl.wbsrc = WB_PC4;
        ctrl.brop  = BR_JUMP;
      end
      OP_B: begin
        ctrl.alua   = 1'b1;
        ctrl.alub   = 1'b1;
        ctrl.immsrc = IMM_B;
        ctrl.brop   = {BR_COND, funct3};
      end
      OP_S: begin
        ctrl.alub   = 1'b1;
        ctrl.dmwr   = 1'b1;
        ctrl.immsrc = IMM_S;
        ctrl.dmctrl = funct3;
      end
      OP_JAL: begin
        ctrl.ruwr   = 1'b1;
        ctrl.alua   = 1'b1;
        ctrl.alub   = 1'b1;
        ctrl.immsrc = IMM_J;
        ctrl.wbsrc  = WB_PC4;
        ctrl.brop   = BR_JUMP;
      end
      OP_LUI: begin
        ctrl.ruwr   = 1'b1;
        ctrl.alub   = 1'b1;
        ctrl.immsrc = IMM_U;
        ctrl.aluop  = 4'b1001;
      end
      OP_AUIPC: begin
        ctrl.ruwr   = 1'b1;
        ctrl.alua   = 1'b1;
        ctrl.alub   = 1'b1;
        ctrl.immsrc = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
    // Illegal encodings must not leave any side-effecting control behind.
    if (illegal) ctrl = '0;
  end
endmodule

// File: rtl/cu_pipe.sv
// Control unit top: DE->EX control register with stall/flush, plus the MUL/DIV latency sequencer.
module cu_pipe
  import cu_pkg::*;
#(
  parameter  int EN_M       = 1,
  parameter  int MD_LATENCY = 4,
  localparam int CNT_W      = $clog2(MD_LATENCY + 1)
) (
  input logic clk,
  input logic rst,
  cu_if.slave bus
);
  ctrl_t            dec_ctrl, ex_ctrl;
  logic             dec_ill, ex_valid, ex_ill;
  md_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             md_busy, md_done, bubble, md_start;

  cu_decode #(.EN_M(EN_M)) u_dec (
    .opcode (bus.OpCode),
    .funct7 (bus.Funct7),
    .funct3 (bus.Funct3),
    .ctrl   (dec_ctrl),
    .illegal(dec_ill)
  );

  assign md_busy  = (state == BUSY) && (cnt != '0);
  assign md_done  = (state == BUSY) && (cnt == '0);
  assign bubble   = bus.Flush_i | bus.Stall_i | ~bus.Valid_de;
  assign md_start = ~bubble & dec_ctrl.mdop[3];

  // On the done cycle the sequencer is not busy, so the next edge captures normally.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (md_busy) begin
      cnt_nx = cnt - CNT_W'(1);
    end else if (md_start) begin
      state_nx = BUSY;
      cnt_nx   = CNT_W'(MD_LATENCY - 1);
    end else begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A busy MUL/DIV is older than anything in DE, so it outranks flush and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl  <= '0;
      ex_valid <= 1'b0;
      ex_ill   <= 1'b0;
    end else if (!md_busy) begin
      if (bubble) begin
        ex_ctrl  <= '0;
        ex_valid <= 1'b0;
        ex_ill   <= 1'b0;
      end else begin
        ex_ctrl  <= dec_ctrl;
        ex_valid <= 1'b1;
        ex_ill   <= dec_ill;
      end
    end
  end

  assign bus.ALUASrc_ex     = ex_ctrl.alua;
  assign bus.ALUBSrc_ex     = ex_ctrl.alub;
  assign bus.DMWr_ex        = ex_ctrl.dmwr;
  assign bus.RUWr_ex        = ex_ctrl.ruwr & ~md_busy;
  assign bus.RuDataWrSrc_ex = ex_ctrl.wbsrc;
  assign bus.ImmSrc_ex      = ex_ctrl.immsrc;
  assign bus.DMCtrl_ex      = ex_ctrl.dmctrl;
  assign bus.ALUOp_ex       = ex_ctrl.aluop;
  assign bus.BrOp_ex        = ex_ctrl.brop;
  assign bus.MDOp_ex        = ex_ctrl.mdop;
  assign bus.Valid_ex       = ex_valid;
  assign bus.Illegal_ex     = ex_ill;
  assign bus.MDBusy         = md_busy;
  assign bus.MDDone         = md_done;
endmodule

// File: tb/tb_cu_pipe.sv
// Bench for cu_pipe: three configurations (M on/lat 4, M off/lat 4, M on/lat 1) share one stimulus stream.
module tb_cu_pipe;
  import cu_pkg::*;

  localparam int EN_TAB  [3] = '{1, 0, 1};
  localparam int LAT_TAB [3] = '{4, 4, 1};
  localparam int B_DONE = 0, B_BUSY = 1, B_ILL = 2, B_VAL = 3, B_RUWR = 25;

  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] op = '0, f7 = '0;
  logic [2:0] f3 = '0;
  logic vde = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [2:0][28:0] act;

  ctrl_t m_c   [3];
  bit    m_v   [3];
  bit    m_il  [3];
  int    m_rem [3];
  int    n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  cu_if ifs[3] ();
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign ifs[g].OpCode   = op;
    assign ifs[g].Funct7   = f7;
    assign ifs[g].Funct3   = f3;
    assign ifs[g].Valid_de = vde;
    assign ifs[g].Stall_i  = stall;
    assign ifs[g].Flush_i  = flush;
    cu_pipe #(.EN_M(EN_TAB[g]), .MD_LATENCY(LAT_TAB[g])) u_dut (
      .clk(clk), .rst(rst), .bus(ifs[g])
    );
    assign act[g] = {ifs[g].ALUASrc_ex, ifs[g].ALUBSrc_ex, ifs[g].DMWr_ex, ifs[g].RUWr_ex,
                     ifs[g].RuDataWrSrc_ex, ifs[g].ImmSrc_ex, ifs[g].DMCtrl_ex, ifs[g].ALUOp_ex,
                     ifs[g].BrOp_ex, ifs[g].MDOp_ex, ifs[g].Valid_ex, ifs[g].Illegal_ex,
                     ifs[g].MDBusy, ifs[g].MDDone};
  end

  // Field-by-field reference decode, keyed on instruction class.
  function automatic void ref_dec(input logic [6:0] o, input logic [6:0] s7, input logic [2:0] s3,
                                  input int en_m, output ctrl_t c, output bit ill, output bit md);
    bit r, i, ld, jr, b, s, j, lui, aui;
    r = (o == 7'b0110011); i = (o == 7'b0010011); ld = (o == 7'b0000011);
    jr = (o == 7'b1100111); b = (o == 7'b1100011); s = (o == 7'b0100011);
    j = (o == 7'b1101111); lui = (o == 7'b0110111); aui = (o == 7'b0010111);
    md  = r && s7 == 7'd1 && en_m != 0;
    ill = !(r || i || ld || jr || b || s || j || lui || aui) ||
          (r && !(s7 == 7'd0 || (s7 == 7'h20 && (s3 == 3'd0 || s3 == 3'd5)) || md));
    c = '0;
    if (ill) begin md = 1'b0; return; end
    c.ruwr   = !(b || s);
    c.alua   = b || j || aui;
    c.alub   = !r;
    c.dmwr   = s;
    c.wbsrc  = ld ? 2'd1 : (j || jr) ? 2'd2 : md ? 2'd3 : 2'd0;
    c.immsrc = s ? 3'd1 : b ? 3'd5 : (lui || aui) ? 3'd2 : j ? 3'd6 : 3'd0;
    c.dmctrl = (ld || s) ? s3 : 3'd0;
    c.aluop  = (r && !md) ? {s7[5], s3} : i ? ((s3 == 3'd5) ? {s7[5], s3} : {1'b0, s3}) :
               lui ? 4'd9 : 4'd0;
    c.brop   = b ? {2'b01, s3} : (j || jr) ? 5'd16 : 5'd0;
    c.mdop   = md ? {1'b1, s3} : 4'd0;
  endfunction

  // m_rem counts the EX cycles a MUL/DIV still occupies, including the current one.
  function automatic logic [28:0] exp_vec(int k);
    ctrl_t c = m_c[k];
    c.ruwr = c.ruwr & (m_rem[k] <= 1);
    return {c, m_v[k], m_il[k], m_rem[k] > 1, m_rem[k] == 1};
  endfunction

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      ctrl_t c; bit il, md;
      if (rst) begin
        m_c[k] = '0; m_v[k] = 0; m_il[k] = 0; m_rem[k] = 0;
      end else if (m_rem[k] > 1) begin
        m_rem[k]--;
      end else begin
        m_rem[k] = 0;
        if (flush || stall || !vde) begin
          m_c[k] = '0; m_v[k] = 0; m_il[k] = 0;
        end else begin
          ref_dec(op, f7, f3, EN_TAB[k], c, il, md);
          m_c[k] = c; m_v[k] = 1; m_il[k] = il;
          if (md) m_rem[k] = LAT_TAB[k];
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic [6:0] o, input logic [6:0] s7, input logic [2:0] s3,
                       input logic v, input logic st, input logic fl);
    op = o; f7 = s7; f3 = s3; vde = v; stall = st; flush = fl;
  endtask

  task automatic drain();
    drive(7'b0110011, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; drive(7'b0110011, 7'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    cycle(); rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (act[k] !== 29'd0) begin
          n_fail++; $display("FAIL reset dut%0d cyc%0d: got %h expected 0", k, c, act[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_capture();
    drive(7'b0110011, 7'b0000000, 3'b000, 1'b1, 1'b0, 1'b0);
    cycle();
    n_chk++;
    if (act[0][16:13] !== 4'b0000 || act[0][B_RUWR] !== 1'b1 || act[0][B_VAL] !== 1'b1) begin
      n_fail++; $display("FAIL capture_add: got %h", act[0]);
    end
    drive(7'b0110011, 7'b0100000, 3'b000, 1'b1, 1'b0, 1'b0);
    cycle();
    n_chk++;
    if (act[0][16:13] !== 4'b1000 || act[0][B_RUWR] !== 1'b1 || act[0][B_VAL] !== 1'b1) begin
      n_fail++; $display("FAIL capture_sub: got %h", act[0]);
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (act[k] !== exp_vec(k)) begin
        n_fail++; $display("FAIL capture_model dut%0d: got %h expected %h", k, act[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_hazards();
    logic [1:0] hz [3] = '{2'b01, 2'b10, 2'b00};  // {flush, stall}
    for (int h = 0; h < 3; h++) begin
      drive(7'b1100011, 7'd0, 3'b000, 1'b1, hz[h][0], hz[h][1]);
      cycle();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (act[k] !== exp_vec(k)) begin
          n_fail++; $display("FAIL hazard%0d dut%0d: got %h expected %h", h, k, act[k], exp_vec(k));
        end
      end
    end
    n_chk++;
    if (act[0][12:8] !== 5'b01000 || act[0][22:20] !== 3'b101 || act[0][28] !== 1'b1) begin
      n_fail++; $display("FAIL hazard_beq: got %h", act[0]);
    end
  endtask

  task automatic test_muldiv();
    logic [4:1] busy_s, done_s, ruwr_s;
    drain();
    drive(7'b0110011, 7'b0000001, 3'b000, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      cycle();
      busy_s[c] = act[0][B_BUSY]; done_s[c] = act[0][B_DONE]; ruwr_s[c] = act[0][B_RUWR];
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (act[k] !== exp_vec(k)) begin
          n_fail++; $display("FAIL muldiv_c%0d dut%0d: got %h expected %h", c, k, act[k], exp_vec(k));
        end
      end
      drive(7'b0110011, 7'd0, 3'b000, 1'b1, 1'b0, c == 1);
    end
    n_chk++;
    if (busy_s !== 4'b0111 || done_s !== 4'b1000 || ruwr_s !== 4'b1000) begin
      n_fail++; $display("FAIL muldiv_seq: busy %b done %b ruwr %b expected 0111 1000 1000",
                         busy_s, done_s, ruwr_s);
    end
    cycle();
    n_chk++;
    if (act[0][7:4] !== 4'b0000 || act[0][B_VAL] !== 1'b1 || act[0][B_RUWR] !== 1'b1) begin
      n_fail++; $display("FAIL muldiv_next_add: got %h", act[0]);
    end
  endtask

  task automatic test_illegal();
    logic [16:0] pats [3] = '{{7'b1111111, 7'd0, 3'd0}, {7'b0110011, 7'b0100000, 3'b001},
                              {7'b0110011, 7'b0000001, 3'b000}};
    drain();
    for (int p = 0; p < 3; p++) begin
      drive(pats[p][16:10], pats[p][9:3], pats[p][2:0], 1'b1, 1'b0, 1'b0);
      cycle();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (act[k] !== exp_vec(k)) begin
          n_fail++; $display("FAIL illegal%0d dut%0d: got %h expected %h", p, k, act[k], exp_vec(k));
        end
      end
      if (p < 2) begin
        n_chk++;
        if (act[0][B_ILL] !== 1'b1 || act[0][28:4] !== 25'd0) begin
          n_fail++; $display("FAIL illegal%0d_flag: got %h", p, act[0]);
        end
      end
    end
    drive(7'b0110011, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      n_chk++;
      if (act[1][B_BUSY] !== 1'b0 || (c == 0 && act[1][B_ILL] !== 1'b1)) begin
        n_fail++; $display("FAIL nom_mul c%0d: got %h", c, act[1]);
      end
      cycle();
    end
  endtask

  task automatic test_latency1();
    drain();
    drive(7'b0110011, 7'b0000001, 3'b100, 1'b1, 1'b0, 1'b0);
    cycle();
    n_chk++;
    if (act[2][B_DONE] !== 1'b1 || act[2][B_BUSY] !== 1'b0 || act[2][B_RUWR] !== 1'b1) begin
      n_fail++; $display("FAIL lat1_done: got %h", act[2]);
    end
    drive(7'b0110011, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    n_chk++;
    if (act[2] !== 29'd0) begin
      n_fail++; $display("FAIL lat1_after: got %h expected 0", act[2]);
    end
  endtask

  task automatic test_reset_busy();
    drain();
    drive(7'b0110011, 7'b0000001, 3'b000, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(7'b0110011, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    n_chk++;
    if (act[0][B_BUSY] !== 1'b1) begin
      n_fail++; $display("FAIL rstbusy_pre: got %h", act[0]);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      if (act[0] !== 29'd0) begin
        n_fail++; $display("FAIL rstbusy c%0d: got %h expected 0", c, act[0]);
      end
      cycle();
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1100011,
                             7'b0100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1111111};
    logic [6:0] f7s [4] = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b0000000};
    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      f7 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : f7s[$urandom_range(0, 3)];
      f3 = 3'($urandom);
      vde = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) == 0);
      cycle();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (act[k] !== exp_vec(k)) begin
          n_fail++; $display("FAIL random%0d dut%0d: got %h expected %h", n, k, act[k], exp_vec(k));
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_hazards();
    test_muldiv();
    test_illegal();
    test_latency1();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cu_pipe.md
Name: cu_pipe

Overview:
- Second-generation control unit. Decodes RV32I plus the optional M extension in the decode stage.
- Registers all control signals into the decode/execute (DE→EX) pipeline boundary, with stall and flush support.
- Sequences multi-cycle MUL/DIV ops with a latency counter and a busy/done handshake to the hazard logic.
- Flags illegal encodings so that execute can trap on them.

Parameters:
- EN_M, 1, enable M-extension decode. When 0, funct7=0000001 R-type is illegal.
- MD_LATENCY, 4, execute cycles per MUL/DIV op. Legal range 1..32.
- CNT_W, $clog2(MD_LATENCY+1), width of the latency counter. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- OpCode  in  7  instruction opcode (DE)
- Funct7  in  7  instruction funct7 (DE)
- Funct3  in  3  instruction funct3 (DE)
- Valid_de  in  1  DE holds a real instruction
- Stall_i  in  1  hazard-unit stall: insert bubble into EX
- Flush_i  in  1  branch/jump flush: kill the DE instruction
- ALUASrc_ex  out  1  ALU A select (0 rs1, 1 PC)
- ALUBSrc_ex  out  1  ALU B select (0 rs2, 1 imm)
- DMWr_ex  out  1  data-memory write enable
- RUWr_ex  out  1  register-file write enable (gated, see Behaviour)
- RuDataWrSrc_ex  out  2  00 ALU, 01 memory, 10 PC+4, 11 MUL/DIV result
- ImmSrc_ex  out  3  000 I, 001 S, 101 B, 010 U, 110 J
- DMCtrl_ex  out  3  memory width/sign (funct3)
- ALUOp_ex  out  4  ALU op {funct7[5], funct3}; LUI=1001
- BrOp_ex  out  5  00000 none, 01fff conditional, 10000 unconditional
- MDOp_ex  out  4  {md_valid, funct3}
- Valid_ex  out  1  EX holds a real instruction
- Illegal_ex  out  1  EX instruction is an illegal encoding
- MDBusy  out  1  MUL/DIV in progress; hazard unit must freeze IF/DE
- MDDone  out  1  one-cycle pulse on the last MUL/DIV execute cycle

Behaviour:
- Base decode for the 9 RV32I types:
  - R: ALUOp {f7[5],f3}.
  - I-op: ALUOp {f7[5],f3} when f3=101, else {0,f3}.
  - Load: RuDataWrSrc 01, DMCtrl f3.
  - JALR: RuDataWrSrc 10, BrOp 10000.
  - B: A=PC, B=imm, ImmSrc 101, BrOp {01,f3}.
  - S: DMWr 1, ImmSrc 001, DMCtrl f3.
  - JAL: A=PC, ImmSrc 110, RuDataWrSrc 10, BrOp 10000.
  - LUI: ImmSrc 010, ALUOp 1001.
  - AUIPC: A=PC, ImmSrc 010, ALUOp 0000.
- MUL/DIV decode (opcode 0110011, funct7 0000001, EN_M=1): RUWr 1, RuDataWrSrc 11, ALUOp 0000, MDOp {1,f3}.
- Illegal encodings:
  - any unlisted opcode;
  - R-type funct7 not in {0000000, 0100000, 0000001 when EN_M};
  - R-type funct7=0100000 with funct3 not in {000,101}.
  - Result: all controls zero, Illegal_ex=1, Valid_ex=Valid_de.
- All outputs except MDBusy/MDDone are registered. Latency: DE inputs appear at *_ex one clock later.
- Reset (rst=1 at edge): every registered output 0, FSM in IDLE, counter 0. MDBusy=0, MDDone=0.
- Edge priority: rst > MD hold > Flush_i > Stall_i > capture.
  - MD hold (MDBusy=1): EX registers keep their value; Flush_i and Stall_i are ignored, since the MUL/DIV is the older instruction.
  - Flush_i or Stall_i: load a bubble (all zeros, Valid_ex=0, Illegal_ex=0).
  - Capture: load the decoded controls. If Valid_de=0, load a bubble.
- MUL/DIV FSM, states IDLE and BUSY:
  - IDLE→BUSY: on capture of a valid MUL/DIV; cnt ← MD_LATENCY-1.
  - BUSY: cnt decrements each clock while cnt≠0. At cnt=0 the next edge goes to IDLE and performs a normal capture.
  - MDBusy = (state==BUSY) && cnt≠0, combinational.
  - MDDone = (state==BUSY) && cnt==0, combinational.
  - RUWr_ex = RUWr_reg & ~MDBusy, so the MUL/DIV result is written only on the MDDone cycle.
  - MD_LATENCY=1: MDBusy is never asserted; MDDone asserts in the first EX cycle.
- Reset mid-BUSY: FSM returns to IDLE and the instruction is dropped, with no MDDone pulse.

Decomposition:
- cu_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_JALR, OP_B, OP_S, OP_JAL, OP_LUI, OP_AUIPC);
  - ImmSrc, RuDataWrSrc and BrOp encodings;
  - FUNCT7_MD;
  - ctrl_t packed struct bundling all EX controls;
  - md_state_t enum {IDLE, BUSY}.
- One sub-module, cu_decode: purely combinational. OpCode/Funct7/Funct3 → ctrl_t plus an illegal flag, with the EN_M parameter.
- cu_pipe holds the EX register, the FSM and the counter.

Test Plan:
- Reset: rst=1 for 2 cycles mid-stream → all outputs 0, MDBusy=0, MDDone=0.
- Capture: ADD (0110011/0000000/000) then SUB (f7 0100000) with Valid_de=1 → next cycle ALUOp_ex=0000 then 1000, RUWr_ex=1, Valid_ex=1.
- Hazards: BEQ with Stall_i=1 → bubble (all 0). Same BEQ with Flush_i=1 and Stall_i=0 → bubble. With neither → BrOp_ex=01000, ImmSrc_ex=101, ALUASrc_ex=1.
- MUL/DIV: MUL (f7 0000001, f3 000) with MD_LATENCY=4 → MDBusy high 3 cycles; MDDone on the 4th; RUWr_ex=1 only on the MDDone cycle; EX held (Flush_i pulse ignored); following ADD captured the next edge.
- Illegal: opcode 1111111, or R-type f7 0100000/f3 001 → Illegal_ex=1, controls 0. With EN_M=0, MUL → Illegal_ex=1, MDBusy never asserted.
- Edge cases: MD_LATENCY=1 MUL → MDDone in the first EX cycle, MDBusy stays 0. rst asserted during BUSY with cnt=2 → IDLE next cycle, no MDDone.
